// File: rtl/sha256_round_core.sv
// rtl/sha256_round_core.sv - iterative SHA-256 compression, one round per clock
module sha256_round_core (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [511:0] block_in,
    input  logic [255:0] h_in,
    output logic [5:0]   k_addr,
    input  logic [31:0]  k,
    output logic         busy,
    output logic         done,
    output logic [255:0] digest
);

    typedef enum logic [1:0] {IDLE, ROUND, FINAL} state_t;

    state_t      state;
    logic [5:0]  round;
    logic [31:0] a, b, c, d, e, f, g, h;
    logic [31:0] hold [8];
    logic [31:0] w [16];
    logic [31:0] t1, t2, w_new;

    function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    function automatic logic [31:0] bsig0(input logic [31:0] x);
        return rotr(x, 2) ^ rotr(x, 13) ^ rotr(x, 22);
    endfunction

    function automatic logic [31:0] bsig1(input logic [31:0] x);
        return rotr(x, 6) ^ rotr(x, 11) ^ rotr(x, 25);
    endfunction

    function automatic logic [31:0] ssig0(input logic [31:0] x);
        return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
    endfunction

    function automatic logic [31:0] ssig1(input logic [31:0] x);
        return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
    endfunction

    // k_addr comes straight from the round register so the ROM output is settled all cycle
    assign k_addr = round;

    always_comb begin
        t1    = h + bsig1(e) + ((e & f) ^ (~e & g)) + k + w[0];
        t2    = bsig0(a) + ((a & b) ^ (a & c) ^ (b & c));
        w_new = ssig1(w[14]) + w[9] + ssig0(w[1]) + w[0];
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state  <= IDLE;
            round  <= 6'd0;
            busy   <= 1'b0;
            done   <= 1'b0;
            digest <= 256'd0;
            a <= 32'd0; b <= 32'd0; c <= 32'd0; d <= 32'd0;
            e <= 32'd0; f <= 32'd0; g <= 32'd0; h <= 32'd0;
            for (int i = 0; i < 8; i++) hold[i] <= 32'd0;
            for (int i = 0; i < 16; i++) w[i] <= 32'd0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        for (int i = 0; i < 16; i++) w[i] <= block_in[511 - 32*i -: 32];
                        for (int i = 0; i < 8; i++) hold[i] <= h_in[255 - 32*i -: 32];
                        a <= h_in[255:224]; b <= h_in[223:192];
                        c <= h_in[191:160]; d <= h_in[159:128];
                        e <= h_in[127:96];  f <= h_in[95:64];
                        g <= h_in[63:32];   h <= h_in[31:0];
                        round <= 6'd0;
                        busy  <= 1'b1;
                        state <= ROUND;
                    end
                end
                ROUND: begin
                    a <= t1 + t2;
                    b <= a;
                    c <= b;
                    d <= c;
                    e <= d + t1;
                    f <= e;
                    g <= f;
                    h <= g;
                    for (int i = 0; i < 15; i++) w[i] <= w[i+1];
                    w[15] <= w_new;
                    if (round == 6'd63) begin
                        round <= 6'd0;
                        state <= FINAL;
                    end else begin
                        round <= round + 6'd1;
                    end
                end
                FINAL: begin
                    digest <= {hold[0] + a, hold[1] + b, hold[2] + c, hold[3] + d,
                               hold[4] + e, hold[5] + f, hold[6] + g, hold[7] + h};
                    done  <= 1'b1;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sha256_round_core.sv
// tb/tb_sha256_round_core.sv - scoreboard bench for sha256_round_core
module tb_sha256_round_core;

    localparam logic [31:0] K_TAB [64] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };

    localparam logic [255:0] IV        = 256'h6a09e667bb67ae853c6ef372a54ff53a510e527f9b05688c1f83d9ab5be0cd19;
    localparam logic [255:0] ABC_DIG   = 256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad;
    localparam logic [255:0] EMPTY_DIG = 256'he3b0c44298fc1c149afbf4c8996fb92427ae41e4649b934ca495991b7852b855;
    localparam logic [511:0] ABC_BLK   = {32'h61626380, 448'h0, 32'h00000018};
    localparam logic [511:0] EMPTY_BLK = {32'h80000000, 480'h0};

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [511:0] block_in;
    logic [255:0] h_in;
    logic [5:0]   k_addr;
    logic [31:0]  k;
    logic         busy;
    logic         done;
    logic [255:0] digest;

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int done_cnt = 0;
    int busy_cnt = 0;
    logic [255:0] exp_q [$];
    int           exp_cyc_q [$];

    sha256_round_core dut (
        .clk(clk), .rst(rst), .start(start), .block_in(block_in), .h_in(h_in),
        .k_addr(k_addr), .k(k), .busy(busy), .done(done), .digest(digest)
    );

    always #5 clk = ~clk;
    assign k = K_TAB[k_addr];

    function automatic logic [31:0] rr(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    function automatic logic [255:0] sha_model(input logic [255:0] hv, input logic [511:0] blk);
        logic [31:0] ws [64];
        logic [31:0] hh [8];
        logic [31:0] v [8];
        logic [31:0] s0, s1, x1, x2;
        for (int t = 0; t < 16; t++) ws[t] = blk[511 - 32*t -: 32];
        for (int t = 16; t < 64; t++) begin
            s0 = rr(ws[t-15], 7) ^ rr(ws[t-15], 18) ^ (ws[t-15] >> 3);
            s1 = rr(ws[t-2], 17) ^ rr(ws[t-2], 19) ^ (ws[t-2] >> 10);
            ws[t] = s1 + ws[t-7] + s0 + ws[t-16];
        end
        for (int i = 0; i < 8; i++) begin
            hh[i] = hv[255 - 32*i -: 32];
            v[i]  = hh[i];
        end
        for (int t = 0; t < 64; t++) begin
            x1 = v[7] + (rr(v[4], 6) ^ rr(v[4], 11) ^ rr(v[4], 25)) + ((v[4] & v[5]) ^ (~v[4] & v[6])) + K_TAB[t] + ws[t];
            x2 = (rr(v[0], 2) ^ rr(v[0], 13) ^ rr(v[0], 22)) + ((v[0] & v[1]) ^ (v[0] & v[2]) ^ (v[1] & v[2]));
            for (int i = 7; i > 0; i--) v[i] = v[i-1];
            v[4] = v[4] + x1;
            v[0] = x1 + x2;
        end
        return {hh[0] + v[0], hh[1] + v[1], hh[2] + v[2], hh[3] + v[3],
                hh[4] + v[4], hh[5] + v[5], hh[6] + v[6], hh[7] + v[7]};
    endfunction

    task automatic check_val(input string tag, input logic [255:0] got, input logic [255:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
        if (busy === 1'b1) busy_cnt++;
        if (done === 1'b1) begin
            done_cnt++;
            if (exp_q.size() == 0) begin
                check_val("sb_pending", exp_q.size(), 1);
            end else begin
                check_val("digest", digest, exp_q.pop_front());
                check_val("done_cycle", cyc, exp_cyc_q.pop_front());
            end
        end
    endtask

    task automatic send(input logic [255:0] hv, input logic [511:0] blk, input logic [255:0] expd);
        h_in     = hv;
        block_in = blk;
        start    = 1'b1;
        exp_q.push_back(expd);
        exp_cyc_q.push_back(cyc + 1 + 65);
        tick();
        start    = 1'b0;
        block_in = {16{$urandom()}};
        h_in     = {8{$urandom()}};
    endtask

    task automatic pulse_ignored();
        h_in     = IV;
        block_in = EMPTY_BLK;
        start    = 1'b1;
        tick();
        start    = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        int n = 0;
        while (done !== 1'b1 && n < budget) begin
            tick();
            n++;
        end
        check_val("done_seen", done, 1);
    endtask

    task automatic wait_addr(input logic [5:0] target);
        int n = 0;
        while (k_addr !== target && n < 80) begin
            tick();
            n++;
        end
        check_val("addr_reached", k_addr, target);
    endtask

    initial begin
        rst = 1'b0;
        start = 1'b0;
        block_in = '0;
        h_in = '0;
        repeat (3) tick();
        check_val("rst_digest", digest, 0);
        check_val("rst_busy", busy, 0);
        check_val("rst_done", done, 0);
        check_val("rst_k_addr", k_addr, 0);
        rst = 1'b1;
        tick();

        // abc with address sequence and busy/done widths
        busy_cnt = 0;
        done_cnt = 0;
        send(IV, ABC_BLK, ABC_DIG);
        for (int r = 0; r < 64; r++) begin
            check_val("k_addr", k_addr, r);
            tick();
        end
        check_val("k_addr_wrap", k_addr, 0);
        check_val("busy_in_final", busy, 1);
        tick();
        check_val("abc_const", digest, ABC_DIG);
        tick();
        check_val("done_width", done, 0);
        check_val("busy_cycles", busy_cnt, 65);
        check_val("done_pulses", done_cnt, 1);

        // empty message
        send(IV, EMPTY_BLK, EMPTY_DIG);
        wait_done(100);
        repeat (2) tick();
        check_val("empty_hold", digest, EMPTY_DIG);

        // start while busy at rounds 10 and 63
        done_cnt = 0;
        send(IV, ABC_BLK, ABC_DIG);
        wait_addr(6'd10);
        pulse_ignored();
        wait_addr(6'd63);
        pulse_ignored();
        wait_done(100);
        repeat (70) tick();
        check_val("busy_ignore_pulses", done_cnt, 1);

        // back-to-back chaining
        send(IV, ABC_BLK, ABC_DIG);
        wait_done(100);
        send(ABC_DIG, EMPTY_BLK, sha_model(ABC_DIG, EMPTY_BLK));
        wait_done(100);
        repeat (2) tick();

        // reset mid-run
        done_cnt = 0;
        send(IV, ABC_BLK, ABC_DIG);
        wait_addr(6'd30);
        rst = 1'b0;
        #1;
        check_val("abort_digest", digest, 0);
        check_val("abort_busy", busy, 0);
        check_val("abort_k_addr", k_addr, 0);
        check_val("abort_done", done, 0);
        void'(exp_q.pop_back());
        void'(exp_cyc_q.pop_back());
        repeat (3) tick();
        rst = 1'b1;
        repeat (70) tick();
        check_val("abort_no_done", done_cnt, 0);
        send(IV, ABC_BLK, ABC_DIG);
        wait_done(100);
        tick();
        check_val("rerun_done_pulses", done_cnt, 1);

        check_val("sb_empty", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
